uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_ctrl_pkg.sv | 15 +
 rtl/uart_tx_serializer.sv | 76 +++++++
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the arbitrated 8N1 UART transmitter.
// Holds the frame state encoding, the data width and the default requester count.
package uart_ctrl_pkg;

    localparam int DATA_BITS    = 8;
    localparam int NREQ_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// Shift register, bit counter and line register for one 8N1 frame.
// It follows the arbiter's frame state and reports when the current phase's last bit is out.
module uart_tx_serializer
    import uart_ctrl_pkg::*;
#(
    parameter int STOP_BITS = 1
)
(
    input  logic                 clk_baud,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic [DATA_BITS-1:0] byte_i,
    input  uart_state_t          state_i,
    output logic                 done_o,
    output logic                 tx_o
);

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           bitCnt_q, bitCnt_d;
    logic                 tx_q, tx_d;

    // The line value is computed one edge ahead so uart_tx leaves a flop.
    always_comb begin
        shift_d  = shift_q;
        bitCnt_d = bitCnt_q;
        tx_d     = 1'b1;
        if (load_i) begin
            shift_d  = byte_i;
            bitCnt_d = '0;
            tx_d     = 1'b0;
        end else begin
            case (state_i)
                START: begin
                    tx_d     = shift_q[0];
                    shift_d  = shift_q >> 1;
                    bitCnt_d = '0;
                end
                DATA: begin
                    if (bitCnt_q == LAST_DATA) begin
                        bitCnt_d = '0;
                    end else begin
                        tx_d     = shift_q[0];
                        shift_d  = shift_q >> 1;
                        bitCnt_d = bitCnt_q + 3'd1;
                    end
                end
                STOP: begin
                    bitCnt_d = (bitCnt_q == LAST_STOP) ? 3'd0 : bitCnt_q + 3'd1;
                end
                default: begin
                    bitCnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_baud or posedge reset) begin
        if (reset) begin
            shift_q  <= '0;
            bitCnt_q <= '0;
            tx_q     <= 1'b1;
        end else begin
            shift_q  <= shift_d;
            bitCnt_q <= bitCnt_d;
            tx_q     <= tx_d;
        end
    end

    assign done_o = ((state_i == DATA) && (bitCnt_q == LAST_DATA)) ||
                    ((state_i == STOP) && (bitCnt_q == LAST_STOP));
    assign tx_o   = tx_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Several byte requesters share one 8N1 transmitter; round-robin or fixed-priority
// arbitration picks the next frame whenever the line is idle.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NREQ      = NREQ_DEFAULT,
    parameter int STOP_BITS = 1
)
(
    input  logic                    clk_baud,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    prio_mode,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    uart_tx,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    frame_done,
    output logic [15:0]             frame_cnt
);

    localparam int GW = $clog2(NREQ);

    uart_state_t          state_q;
    logic [GW-1:0]        grantId_q;
    logic [GW-1:0]        lastGrant_q;
    logic                 busy_q;
    logic                 frameDone_q;
    logic [15:0]          frameCnt_q;

    logic [GW-1:0]        winner_d;
    logic [DATA_BITS-1:0] selByte_d;
    logic                 transfer;
    logic                 serDone;

    // Loops run downwards so the lowest index (or nearest round-robin offset) wins last.
    always_comb begin
        int idx;
        idx      = 0;
        winner_d = '0;
        if (prio_mode) begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (req_valid[i]) winner_d = GW'(i);
            end
        end else begin
            for (int off = NREQ; off >= 1; off--) begin
                idx = (int'(lastGrant_q) + off) % NREQ;
                if (req_valid[idx]) winner_d = GW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if ((state_q == IDLE) && enable && (|req_valid)) begin
            req_ready[winner_d] = 1'b1;
        end
    end

    assign transfer = |(req_valid & req_ready);

    always_comb begin
        selByte_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner_d == GW'(i)) selByte_d = req_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk_baud or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grantId_q   <= '0;
            lastGrant_q <= GW'(NREQ - 1);
            busy_q      <= 1'b0;
            frameDone_q <= 1'b0;
            frameCnt_q  <= '0;
        end else begin
            frameDone_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (transfer) begin
                        state_q     <= START;
                        grantId_q   <= winner_d;
                        lastGrant_q <= winner_d;
                        busy_q      <= 1'b1;
                    end
                end
                START: begin
                    state_q <= DATA;
                end
                DATA: begin
                    if (serDone) state_q <= STOP;
                end
                STOP: begin
                    if (serDone) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        frameDone_q <= 1'b1;
                        frameCnt_q  <= frameCnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    uart_tx_serializer #(
        .STOP_BITS (STOP_BITS)
    ) u_serializer (
        .clk_baud (clk_baud),
        .reset    (reset),
        .load_i   (transfer),
        .byte_i   (selByte_d),
        .state_i  (state_q),
        .done_o   (serDone),
        .tx_o     (uart_tx)
    );

    assign busy       = busy_q;
    assign grant_id   = grantId_q;
    assign frame_done = frameDone_q;
    assign frame_cnt  = frameCnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one instance with one stop bit, one with two,
// each frame checked bit by bit against hand-computed line values.
module tb_uart_tx_arbiter;

    logic clk_baud = 1'b0;
    always #5 clk_baud = ~clk_baud;

    logic        resetA = 1'b0, enableA = 1'b0, prioA = 1'b0;
    logic [3:0]  validA = '0;
    logic [31:0] dataA  = '0;
    logic [3:0]  readyA;
    logic        txA, busyA, doneA;
    logic [1:0]  grantA;
    logic [15:0] cntA;

    logic        resetB = 1'b0, enableB = 1'b0, prioB = 1'b0;
    logic [3:0]  validB = '0;
    logic [31:0] dataB  = '0;
    logic [3:0]  readyB;
    logic        txB, busyB, doneB;
    logic [1:0]  grantB;
    logic [15:0] cntB;

    logic        sel = 1'b0;
    logic [31:0] obsTx, obsBusy, obsDone, obsGrant, obsCnt, obsReady;

    int total = 0;
    int bad = 0;
    int stepCount = 0;
    int tPrev = 0;
    int tNow = 0;
    int expIds [5] = '{0, 1, 2, 3, 0};

    uart_tx_arbiter #(.NREQ(4), .STOP_BITS(1)) dutA (
        .clk_baud   (clk_baud),
        .reset      (resetA),
        .enable     (enableA),
        .prio_mode  (prioA),
        .req_valid  (validA),
        .req_data   (dataA),
        .req_ready  (readyA),
        .uart_tx    (txA),
        .busy       (busyA),
        .grant_id   (grantA),
        .frame_done (doneA),
        .frame_cnt  (cntA)
    );

    uart_tx_arbiter #(.NREQ(4), .STOP_BITS(2)) dutB (
        .clk_baud   (clk_baud),
        .reset      (resetB),
        .enable     (enableB),
        .prio_mode  (prioB),
        .req_valid  (validB),
        .req_data   (dataB),
        .req_ready  (readyB),
        .uart_tx    (txB),
        .busy       (busyB),
        .grant_id   (grantB),
        .frame_done (doneB),
        .frame_cnt  (cntB)
    );

    assign obsTx    = sel ? 32'(txB)    : 32'(txA);
    assign obsBusy  = sel ? 32'(busyB)  : 32'(busyA);
    assign obsDone  = sel ? 32'(doneB)  : 32'(doneA);
    assign obsGrant = sel ? 32'(grantB) : 32'(grantA);
    assign obsCnt   = sel ? 32'(cntB)   : 32'(cntA);
    assign obsReady = sel ? 32'(readyB) : 32'(readyA);

    task automatic step();
        @(posedge clk_baud);
        #1;
        stepCount++;
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d,
                                 input logic en, input logic pm);
        if (sel) begin
            validB = v; dataB = d; enableB = en; prioB = pm;
        end else begin
            validA = v; dataA = d; enableA = en; prioA = pm;
        end
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Entered just after the transfer edge; leaves just after the last stop edge.
    task automatic checkFrame(input logic [7:0] b, input int g, input int stops);
        checkOutput("start bit", obsTx, 32'h0);
        checkOutput("busy in frame", obsBusy, 32'h1);
        checkOutput("grant_id", obsGrant, 32'(g));
        for (int k = 0; k < 8; k++) begin
            step();
            checkOutput($sformatf("data bit %0d", k), obsTx, 32'(b[k]));
        end
        for (int s = 0; s < stops; s++) begin
            step();
            checkOutput($sformatf("stop bit %0d", s), obsTx, 32'h1);
            checkOutput("no early done", obsDone, 32'h0);
            checkOutput("busy in stop", obsBusy, 32'h1);
        end
        step();
        checkOutput("frame_done pulse", obsDone, 32'h1);
        checkOutput("busy after frame", obsBusy, 32'h0);
        checkOutput("idle line", obsTx, 32'h1);
    endtask

    initial begin
        // Reset values and a single 0x55 frame
        #1;
        resetA = 1'b1;
        resetB = 1'b1;
        #1;
        checkOutput("rst tx", obsTx, 32'h1);
        checkOutput("rst busy", obsBusy, 32'h0);
        checkOutput("rst grant", obsGrant, 32'h0);
        checkOutput("rst done", obsDone, 32'h0);
        checkOutput("rst cnt", obsCnt, 32'h0);
        step();
        step();
        resetA = 1'b0;
        applyStimulus(4'b0001, 32'h0000_0055, 1'b1, 1'b0);
        checkOutput("t1 ready", obsReady, 32'h1);
        step();
        applyStimulus(4'b0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        checkOutput("t1 ready busy", obsReady, 32'h0);
        checkFrame(8'h55, 0, 1);
        checkOutput("t1 cnt", obsCnt, 32'h1);
        step();
        checkOutput("t1 done low", obsDone, 32'h0);
        checkOutput("t1 cnt hold", obsCnt, 32'h1);

        // Round-robin over four held requesters
        resetA = 1'b1;
        #1;
        checkOutput("t2 rst cnt", obsCnt, 32'h0);
        step();
        resetA = 1'b0;
        applyStimulus(4'b1111, 32'h1312_1110, 1'b1, 1'b0);
        for (int n = 0; n < 5; n++) begin
            checkOutput("t2 ready", obsReady, 32'h1 << expIds[n]);
            step();
            tNow = stepCount;
            if (n > 0) checkOutput("t2 spacing", 32'(tNow - tPrev), 32'd11);
            tPrev = tNow;
            checkFrame(8'(16 + expIds[n]), expIds[n], 1);
            checkOutput("t2 cnt", obsCnt, 32'(n + 1));
        end
        applyStimulus(4'b0000, 32'h0, 1'b1, 1'b0);

        // Fixed priority starves requester 2 until requester 0 drops
        applyStimulus(4'b0101, 32'h00A2_00A0, 1'b1, 1'b1);
        checkOutput("t3 ready r0", obsReady, 32'h1);
        step();
        checkFrame(8'hA0, 0, 1);
        checkOutput("t3 ready r0 again", obsReady, 32'h1);
        step();
        checkFrame(8'hA0, 0, 1);
        applyStimulus(4'b0100, 32'h00A2_00A0, 1'b1, 1'b1);
        checkOutput("t3 ready r2", obsReady, 32'h4);
        step();
        checkFrame(8'hA2, 2, 1);
        applyStimulus(4'b0000, 32'h0, 1'b1, 1'b0);
        checkOutput("t3 cnt", obsCnt, 32'd8);

        // Enable gating, including a drop mid-frame
        applyStimulus(4'b0010, 32'h0000_6B00, 1'b0, 1'b0);
        checkOutput("t4 ready blocked", obsReady, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("t4 tx idle", obsTx, 32'h1);
            checkOutput("t4 busy idle", obsBusy, 32'h0);
        end
        applyStimulus(4'b0010, 32'h0000_6B00, 1'b1, 1'b0);
        checkOutput("t4 ready r1", obsReady, 32'h2);
        step();
        applyStimulus(4'b0010, 32'h0000_6B00, 1'b0, 1'b0);
        checkFrame(8'h6B, 1, 1);
        checkOutput("t4 cnt", obsCnt, 32'd9);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("t4 no regrant", obsBusy, 32'h0);
            checkOutput("t4 tx stays", obsTx, 32'h1);
            checkOutput("t4 ready off", obsReady, 32'h0);
        end
        applyStimulus(4'b0000, 32'h0, 1'b0, 1'b0);

        // Reset during data bit 3 abandons the frame
        applyStimulus(4'b0001, 32'h0000_0035, 1'b1, 1'b0);
        checkOutput("t5 ready", obsReady, 32'h1);
        step();
        applyStimulus(4'b0000, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step();
        checkOutput("t5 bit3", obsTx, 32'h0);
        checkOutput("t5 busy", obsBusy, 32'h1);
        resetA = 1'b1;
        #1;
        checkOutput("t5 rst tx", obsTx, 32'h1);
        checkOutput("t5 rst busy", obsBusy, 32'h0);
        checkOutput("t5 rst cnt", obsCnt, 32'h0);
        checkOutput("t5 rst done", obsDone, 32'h0);
        step();
        step();
        checkOutput("t5 no done", obsDone, 32'h0);
        resetA = 1'b0;
        applyStimulus(4'b1111, 32'h4433_2211, 1'b1, 1'b0);
        checkOutput("t5 first grant", obsReady, 32'h1);
        step();
        applyStimulus(4'b0000, 32'h0, 1'b1, 1'b0);
        checkFrame(8'h11, 0, 1);
        checkOutput("t5 cnt", obsCnt, 32'h1);

        // Two stop bits, back-to-back frames
        sel = 1'b1;
        resetB = 1'b0;
        #1;
        checkOutput("t6 rst tx", obsTx, 32'h1);
        checkOutput("t6 rst busy", obsBusy, 32'h0);
        applyStimulus(4'b0011, 32'h0000_7E81, 1'b1, 1'b0);
        checkOutput("t6 ready r0", obsReady, 32'h1);
        step();
        tPrev = stepCount;
        checkFrame(8'h81, 0, 2);
        checkOutput("t6 ready r1", obsReady, 32'h2);
        step();
        tNow = stepCount;
        checkOutput("t6 spacing", 32'(tNow - tPrev), 32'd12);
        applyStimulus(4'b0000, 32'h0, 1'b1, 1'b0);
        checkFrame(8'h7E, 1, 2);
        checkOutput("t6 cnt", obsCnt, 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
